// File: rtl/cart_dump_streamer.sv
// Cartridge ROM dump engine: walks a PRG or CHR address range, settles, latches each byte, streams it to the UART.
// Build option DUMP_CHECKSUM_EN appends an 8-bit mod-256 sum of the dumped bytes after the last data byte.
module cart_dump_streamer #(
    parameter int ADDR_W        = 15,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              start,
    input  logic              chan_sel,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_data,
    output logic              romsel_n,
    output logic [ADDR_W-1:0] ppu_addr,
    input  logic [7:0]        ppu_data,
    output logic              ppu_rd_n,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   byte_count
);
    typedef enum logic [3:0] {
        IDLE, SETTLE, LATCH, SEND, WAIT_BUSY, WAIT_ACK, NEXT,
`ifdef DUMP_CHECKSUM_EN
        CSUM,
`endif
        FINISH
    } state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t            state;
    logic              chan_q;
    logic [ADDR_W-1:0] last_q;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        settle_cnt;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]        sum;
    logic              csum_phase;
`endif

    // Only the selected bus sees the walking address; the idle bus is parked at 0.
    assign cpu_addr = chan_q ? '0 : addr;
    assign ppu_addr = chan_q ? addr : '0;
    assign busy     = (state != IDLE);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            chan_q     <= 1'b0;
            last_q     <= '0;
            addr       <= '0;
            settle_cnt <= '0;
            romsel_n   <= 1'b1;
            ppu_rd_n   <= 1'b1;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            done       <= 1'b0;
            byte_count <= '0;
`ifdef DUMP_CHECKSUM_EN
            sum        <= '0;
            csum_phase <= 1'b0;
`endif
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    chan_q     <= chan_sel;
                    last_q     <= last_addr;
                    addr       <= '0;
                    byte_count <= '0;
                    settle_cnt <= SETTLE_LOAD;
                    romsel_n   <= chan_sel;
                    ppu_rd_n   <= ~chan_sel;
`ifdef DUMP_CHECKSUM_EN
                    sum        <= '0;
                    csum_phase <= 1'b0;
`endif
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == 8'd0) state <= LATCH;
                    else settle_cnt <= settle_cnt - 8'd1;
                end
                LATCH: begin
                    tx_data <= chan_q ? ppu_data : cpu_data;
`ifdef DUMP_CHECKSUM_EN
                    sum     <= sum + (chan_q ? ppu_data : cpu_data);
`endif
                    state   <= SEND;
                end
                SEND: if (tx_ready) begin
                    tx_start <= 1'b1;
                    state    <= WAIT_BUSY;
                end
                // The UART dropping ready is the only proof it took the byte.
                WAIT_BUSY: if (!tx_ready) state <= WAIT_ACK;
                WAIT_ACK: if (tx_ready) begin
`ifdef DUMP_CHECKSUM_EN
                    if (csum_phase) begin
                        state <= FINISH;
                    end else begin
                        byte_count <= byte_count + 1'b1;
                        state      <= NEXT;
                    end
`else
                    byte_count <= byte_count + 1'b1;
                    state      <= NEXT;
`endif
                end
                NEXT: begin
                    if (addr == last_q) begin
`ifdef DUMP_CHECKSUM_EN
                        state <= CSUM;
`else
                        state <= FINISH;
`endif
                    end else begin
                        addr       <= addr + 1'b1;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= SETTLE;
                    end
                end
`ifdef DUMP_CHECKSUM_EN
                CSUM: begin
                    tx_data    <= sum;
                    csum_phase <= 1'b1;
                    state      <= SEND;
                end
`endif
                FINISH: begin
                    romsel_n <= 1'b1;
                    ppu_rd_n <= 1'b1;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cart_dump_streamer.sv
// Bench for cart_dump_streamer: ROM bus models with 3-cycle access time, a UART model, and a queue-based byte model.
module tb_cart_dump_streamer;
    localparam int AW        = 4;
    localparam int UART_BUSY = 10;

    logic          CLOCK_50 = 1'b0;
    logic          RESET_N  = 1'b0;
    logic          start    = 1'b0;
    logic          chan_sel = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [AW-1:0] cpu_addr, ppu_addr;
    logic [7:0]    cpu_data, ppu_data, tx_data;
    logic          romsel_n, ppu_rd_n, tx_start, tx_ready, busy, done;
    logic [AW:0]   byte_count;

    int vecs = 0;
    int errs = 0;

    logic [7:0]    rom_cpu [16];
    logic [7:0]    rom_ppu [16];
    logic [AW-1:0] ca_d [3];
    logic [AW-1:0] pa_d [3];
    logic          uart_rdy = 1'b1;
    int            ucnt = 0;
    logic          hold = 1'b0;

    logic [7:0] exp_q [$];
    int         exp_count = 0;
    logic [7:0] cap_q [$];
    int         idx = 0;
    int         done_cnt = 0;
    logic       cur_ch = 1'b0;
    logic       prev_txs = 1'b0;

    cart_dump_streamer #(.ADDR_W(AW), .SETTLE_CYCLES(4)) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .start(start), .chan_sel(chan_sel),
        .last_addr(last_addr), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .romsel_n(romsel_n),
        .ppu_addr(ppu_addr), .ppu_data(ppu_data), .ppu_rd_n(ppu_rd_n), .tx_start(tx_start),
        .tx_data(tx_data), .tx_ready(tx_ready), .busy(busy), .done(done), .byte_count(byte_count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Bus data follows the address three cycles late, so an early sample returns the previous byte.
    always @(posedge CLOCK_50) begin
        ca_d[0] <= cpu_addr; ca_d[1] <= ca_d[0]; ca_d[2] <= ca_d[1];
        pa_d[0] <= ppu_addr; pa_d[1] <= pa_d[0]; pa_d[2] <= pa_d[1];
    end
    assign cpu_data = rom_cpu[ca_d[2]];
    assign ppu_data = rom_ppu[pa_d[2]];

    always @(posedge CLOCK_50) begin
        if (tx_start) begin
            uart_rdy <= 1'b0;
            ucnt     <= UART_BUSY;
        end else if (ucnt > 0) begin
            ucnt <= ucnt - 1;
            if (ucnt == 1) uart_rdy <= 1'b1;
        end
    end
    assign tx_ready = uart_rdy & ~hold;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vecs++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (RESET_N) begin
            if (start && !busy) begin
                idx = 0; done_cnt = 0; cap_q.delete(); cur_ch = chan_sel;
            end
            if (tx_start) begin
                chk("tx_start_while_ready", tx_ready, 1);
                chk("tx_single_pulse", prev_txs, 0);
                if (idx < exp_q.size()) chk("tx_data", tx_data, exp_q[idx]);
                else chk("tx_extra_byte", idx, exp_q.size());
                if (idx < exp_count) chk("tx_addr", cur_ch ? ppu_addr : cpu_addr, idx);
                cap_q.push_back(tx_data);
                idx++;
            end
            prev_txs = tx_start;
            if (done) begin
                done_cnt++;
                chk("done_byte_count", byte_count, exp_count);
                chk("done_all_sent", idx, exp_q.size());
            end
            if (busy) begin
                chk("sel_strobe_low", cur_ch ? ppu_rd_n : romsel_n, 0);
                chk("unsel_strobe_high", cur_ch ? romsel_n : ppu_rd_n, 1);
                chk("unsel_addr_zero", cur_ch ? cpu_addr : ppu_addr, 0);
            end else begin
                chk("idle_strobes", {romsel_n, ppu_rd_n}, 2'b11);
            end
        end
    end

    task automatic run_dump(input logic ch, input int last);
        logic [7:0] b, sum;
        exp_q.delete();
        sum = 8'h00;
        for (int i = 0; i <= last; i++) begin
            b = ch ? rom_ppu[i] : rom_cpu[i];
            exp_q.push_back(b);
            sum = sum + b;
        end
`ifdef DUMP_CHECKSUM_EN
        exp_q.push_back(sum);
`endif
        exp_count = last + 1;
        @(posedge CLOCK_50); #1;
        start = 1'b1; chan_sel = ch; last_addr = AW'(last);
        @(posedge CLOCK_50); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int max);
        bit seen = 0;
        for (int n = 0; n < max && !seen; n++) begin
            @(negedge CLOCK_50);
            if (done) seen = 1;
        end
        @(posedge CLOCK_50); #1;
        chk({nm, "_done_timeout"}, seen, 1);
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_cpu_addr"}, cpu_addr, 0);
        chk({nm, "_ppu_addr"}, ppu_addr, 0);
        chk({nm, "_strobes"}, {romsel_n, ppu_rd_n}, 2'b11);
        chk({nm, "_tx"}, {tx_start, tx_data}, 0);
        chk({nm, "_busy_done"}, {busy, done}, 0);
        chk({nm, "_byte_count"}, byte_count, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            rom_cpu[i] = 8'(i * 37 + 5);
            rom_ppu[i] = 8'(i * 23 + 9);
        end
        rom_cpu[0] = 8'hF0; rom_cpu[1] = 8'h03; rom_cpu[2] = 8'h00; rom_cpu[3] = 8'hF0;
        rom_ppu[0] = 8'hA5;

        repeat (3) @(posedge CLOCK_50); #1;
        check_reset_vals("por");
        RESET_N = 1'b1;

        // CPU dump of four bytes
        run_dump(1'b0, 3);
        wait_done("cpu4", 1000);
        chk("cpu4_b0", cap_q[0], 8'hF0);
        chk("cpu4_b1", cap_q[1], 8'h03);
        chk("cpu4_b2", cap_q[2], 8'h00);
        chk("cpu4_b3", cap_q[3], 8'hF0);
        chk("cpu4_count", byte_count, 4);
        chk("cpu4_done_pulses", done_cnt, 1);

        // single-byte PPU dump
        run_dump(1'b1, 0);
        wait_done("ppu1", 1000);
        chk("ppu1_b0", cap_q[0], 8'hA5);
        chk("ppu1_count", byte_count, 1);
`ifdef DUMP_CHECKSUM_EN
        chk("ppu1_tx_count", cap_q.size(), 2);
`else
        chk("ppu1_tx_count", cap_q.size(), 1);
`endif

        // UART not ready: no tx_start until it rises
        hold = 1'b1;
        run_dump(1'b0, 1);
        repeat (60) @(posedge CLOCK_50); #1;
        chk("hold_no_tx", cap_q.size(), 0);
        chk("hold_busy", busy, 1);
        hold = 1'b0;
        wait_done("hold", 1000);
        chk("hold_b0", cap_q[0], 8'hF0);
        chk("hold_b1", cap_q[1], 8'h03);

        // full address range, with a start while busy that must be ignored
        run_dump(1'b0, 15);
        repeat (30) @(posedge CLOCK_50); #1;
        start = 1'b1; chan_sel = 1'b1; last_addr = '0;
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        wait_done("full", 3000);
        chk("full_count", byte_count, 16);
        chk("full_done_pulses", done_cnt, 1);
        chk("full_last_byte", cap_q[15], 8'(15 * 37 + 5));

        // reset while waiting on the UART ack of byte 2
        run_dump(1'b0, 3);
        for (int n = 0; n < 1000 && cap_q.size() < 2; n++) begin
            @(posedge CLOCK_50); #1;
        end
        chk("rst_reached_byte2", cap_q.size(), 2);
        repeat (3) @(posedge CLOCK_50); #1;
        RESET_N = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(posedge CLOCK_50); #1;
        chk("midrst_no_done", done_cnt, 0);
        RESET_N = 1'b1;
        run_dump(1'b0, 3);
        wait_done("restart", 1000);
        chk("restart_b0", cap_q[0], 8'hF0);
        chk("restart_count", byte_count, 4);

        // checksum payload
        rom_cpu[0] = 8'hFF; rom_cpu[1] = 8'hFF; rom_cpu[2] = 8'h03;
        run_dump(1'b0, 2);
        wait_done("csum", 1000);
        chk("csum_count", byte_count, 3);
        chk("csum_b2", cap_q[2], 8'h03);
`ifdef DUMP_CHECKSUM_EN
        chk("csum_tx_count", cap_q.size(), 4);
        chk("csum_sum_byte", cap_q[3], 8'h01);
`else
        chk("csum_tx_count", cap_q.size(), 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
